karatsuba_seq16: RTL and testbench

//  Multi-cycle 16x16 unsigned multiplier; wraps one 8x8 karatsuba core (X,Y->Z).

---
 rtl/karatsuba_seq16.sv | 179 +++++++++++++++++
 tb/tb_karatsuba_seq16.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/karatsuba_seq16.sv
// Sequential 16x16 unsigned multiplier sharing one 8x8 Karatsuba core over three cycles.
// Optional KSEQ_ZERO_SKIP_EN: a zero operand bypasses the multiply states.
module karatsuba_core8 #(
    parameter int W = 8
) (
    input  logic [W-1:0]   X,
    input  logic [W-1:0]   Y,
    output logic [2*W-1:0] Z
);
    localparam int H = W / 2;

    logic [H-1:0]     x0, x1, y0, y1;
    logic [H:0]       sx, sy;
    logic [2*H-1:0]   p0, p2;
    logic [2*H+1:0]   ps, p1;

    always_comb begin
        x0 = X[H-1:0];
        x1 = X[W-1:H];
        y0 = Y[H-1:0];
        y1 = Y[W-1:H];
        sx = {1'b0, x1} + {1'b0, x0};
        sy = {1'b0, y1} + {1'b0, y0};
        p0 = {{H{1'b0}}, x0} * {{H{1'b0}}, y0};
        p2 = {{H{1'b0}}, x1} * {{H{1'b0}}, y1};
        ps = {{(H+1){1'b0}}, sx} * {{(H+1){1'b0}}, sy};
        // Middle term is always non-negative, so the subtraction never wraps
        p1 = ps - {2'b00, p2} - {2'b00, p0};
        Z  = {p2, p0} + ({{(W-2){1'b0}}, p1} << H);
    end
endmodule

module karatsuba_seq16 #(
    parameter int HALF_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2*HALF_W-1:0] A,
    input  logic [2*HALF_W-1:0] B,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [4*HALF_W-1:0] P,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy
);
    localparam int W  = 2 * HALF_W;
    localparam int MW = W + 2;
    localparam int PW = 2 * W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_MID,
        S_COMB,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  z0_q, z0_d;
    logic [W-1:0]  z2_q, z2_d;
    logic [MW-1:0] mid_q, mid_d;
    logic [PW-1:0] p_q, p_d;

    logic [HALF_W-1:0] core_x, core_y;
    logic [W-1:0]      core_z;

    logic [HALF_W:0] sa, sb;
    logic [MW-1:0]   sa_term, sb_term, cc_term, mid_c, z1;
    logic [PW-1:0]   prod;

    karatsuba_core8 #(.W(HALF_W)) u_core (
        .X (core_x),
        .Y (core_y),
        .Z (core_z)
    );

    always_comb begin
        sa = {1'b0, a_q[W-1:HALF_W]} + {1'b0, a_q[HALF_W-1:0]};
        sb = {1'b0, b_q[W-1:HALF_W]} + {1'b0, b_q[HALF_W-1:0]};
    end

    // Core only sees the low 8 bits of the sums; carries are folded in here
    always_comb begin
        sa_term = sa[HALF_W] ? {2'b00, sb[HALF_W-1:0], {HALF_W{1'b0}}} : '0;
        sb_term = sb[HALF_W] ? {2'b00, sa[HALF_W-1:0], {HALF_W{1'b0}}} : '0;
        cc_term = (sa[HALF_W] & sb[HALF_W]) ? {2'b01, {W{1'b0}}} : '0;
        mid_c   = {2'b00, core_z} + sa_term + sb_term + cc_term;
        z1      = mid_q - {2'b00, z2_q} - {2'b00, z0_q};
        prod    = {z2_q, z0_q} + ({{(PW-MW){1'b0}}, z1} << HALF_W);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        z0_d    = z0_q;
        z2_d    = z2_q;
        mid_d   = mid_q;
        p_d     = p_q;
        core_x  = '0;
        core_y  = '0;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d = A;
                    b_d = B;
`ifdef KSEQ_ZERO_SKIP_EN
                    if ((A == '0) || (B == '0)) begin
                        p_d     = '0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LO;
                    end
`else
                    state_d = S_LO;
`endif
                end
            end
            S_LO: begin
                core_x  = a_q[HALF_W-1:0];
                core_y  = b_q[HALF_W-1:0];
                z0_d    = core_z;
                state_d = S_HI;
            end
            S_HI: begin
                core_x  = a_q[W-1:HALF_W];
                core_y  = b_q[W-1:HALF_W];
                z2_d    = core_z;
                state_d = S_MID;
            end
            S_MID: begin
                core_x  = sa[HALF_W-1:0];
                core_y  = sb[HALF_W-1:0];
                mid_d   = mid_c;
                state_d = S_COMB;
            end
            S_COMB: begin
                p_d     = prod;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            z0_q    <= '0;
            z2_q    <= '0;
            mid_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            z0_q    <= z0_d;
            z2_q    <= z2_d;
            mid_q   <= mid_d;
            p_q     <= p_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        out_valid = (state_q == S_DONE);
        P         = p_q;
    end
endmodule

// File: tb/tb_karatsuba_seq16.sv
// Directed bench for karatsuba_seq16: products, latency, backpressure, reset abort.
module tb_karatsuba_seq16;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] A, B;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] P;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

`ifdef KSEQ_ZERO_SKIP_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 5;
`endif

    karatsuba_seq16 dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .P         (P),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        A        = a;
        B        = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A        = ~a;
        B        = ~b;
    endtask

    task automatic run_job(input string tag, input logic [15:0] a,
                           input logic [15:0] b, input logic [31:0] exp,
                           input int exp_lat);
        int lat;
        start(a, b);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_P"}, P, exp);
    endtask

    task automatic retire(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_ovld"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        A         = '0;
        B         = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ovld", {31'd0, out_valid}, 32'd0);
        chk("rst_P", P, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_job("x1111", 16'h1111, 16'h1111, 32'h01234321, 5);
        retire("x1111");
        run_job("xffff", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 5);
        retire("xffff");
        run_job("x80ff", 16'h80FF, 16'hFF80, 32'h80BE8080, 5);
        retire("x80ff");
        run_job("x100", 16'h0100, 16'h0100, 32'h00010000, 5);
        retire("x100");
        run_job("ffx1", 16'hFFFF, 16'h0001, 32'h0000FFFF, 5);
        retire("ffx1");

        out_ready = 1'b0;
        run_job("bp", 16'h1234, 16'h5678, 32'h06260060, 5);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_P", P, 32'h06260060);
            chk("bp_hold_ovld", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        retire("bp");

        start(16'hABCD, 16'h1357);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        chk("mid_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ovld", {31'd0, out_valid}, 32'd0);
        chk("abort_P", P, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_job("x3x5", 16'd3, 16'd5, 32'd15, 5);
        retire("x3x5");

        run_job("zero", 16'h0000, 16'hABCD, 32'd0, ZLAT);
        retire("zero");
        run_job("zeroB", 16'h1234, 16'h0000, 32'd0, ZLAT);
        retire("zeroB");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
